// File: rtl/alu_decode_stage_pkg.sv
// Shared ALU decode definitions: ALUop codes, MIPS opcode/funct values,
// the decoded bundle carried through the stage, and elastic-buffer states.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_SEXT,
    IMM_ZEXT,
    IMM_LUI
  } imm_kind_e;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_state_e;

  typedef struct packed {
    logic [2:0]      alu_op;
    logic            src_imm;
    logic            zero_a;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      waddr;
    logic            wen;
    logic            illegal;
  } dec_bundle_t;

  function automatic logic [XLEN-1:0] extend_imm(input imm_kind_e kind,
                                                 input logic [15:0] imm16);
    case (kind)
      IMM_SEXT: return {{(XLEN-16){imm16[15]}}, imm16};
      IMM_ZEXT: return {{(XLEN-16){1'b0}}, imm16};
      IMM_LUI:  return {imm16, {(XLEN-16){1'b0}}};
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Instruction-in / decoded-bundle-out handshake bus of the ID->EX decode stage.
// master = producer/consumer side, slave = the decode stage.
interface alu_decode_stage_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_instr;

  logic                  out_valid;
  logic                  out_ready;
  logic [2:0]            out_alu_op;
  logic                  out_src_imm;
  logic                  out_zero_a;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [4:0]            out_rs;
  logic [4:0]            out_rt;
  logic [4:0]            out_waddr;
  logic                  out_wen;
  logic                  out_illegal;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_alu_op, out_src_imm, out_zero_a,
           out_imm, out_rs, out_rt, out_waddr, out_wen, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_alu_op, out_src_imm, out_zero_a,
           out_imm, out_rs, out_rt, out_waddr, out_wen, out_illegal
  );
endinterface

// File: rtl/alu_decode_stage_decode_comb.sv
// Pure combinational MIPS instruction -> ALU decode bundle.
// ALU_DECODE_TRAP_EN: when defined, unsupported encodings raise bundle.illegal.
module alu_decode_comb
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] instr,
  output dec_bundle_t           bundle
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       legal;
  logic       write_rt;
  logic       write_rd;
  logic [4:0] dest;
  imm_kind_e  kind;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    bundle         = '0;
    bundle.rs      = instr[25:21];
    bundle.rt      = instr[20:16];
    bundle.alu_op  = ALU_AND;
    legal          = 1'b1;
    write_rt       = 1'b0;
    write_rd       = 1'b0;
    kind           = IMM_NONE;
    dest           = '0;

    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  bundle.alu_op = ALU_ADD;
          FN_SUB:  bundle.alu_op = ALU_SUB;
          FN_AND:  bundle.alu_op = ALU_AND;
          FN_OR:   bundle.alu_op = ALU_OR;
          FN_XOR:  bundle.alu_op = ALU_XOR;
          FN_NOR:  bundle.alu_op = ALU_NOR;
          FN_SLT:  bundle.alu_op = ALU_SLT;
          FN_SLTU: bundle.alu_op = ALU_SLTU;
          default: legal = 1'b0;
        endcase
        write_rd = 1'b1;
      end
      OP_ADDIU: begin bundle.alu_op = ALU_ADD;  kind = IMM_SEXT; write_rt = 1'b1; end
      OP_SLTI:  begin bundle.alu_op = ALU_SLT;  kind = IMM_SEXT; write_rt = 1'b1; end
      OP_SLTIU: begin bundle.alu_op = ALU_SLTU; kind = IMM_SEXT; write_rt = 1'b1; end
      OP_ANDI:  begin bundle.alu_op = ALU_AND;  kind = IMM_ZEXT; write_rt = 1'b1; end
      OP_ORI:   begin bundle.alu_op = ALU_OR;   kind = IMM_ZEXT; write_rt = 1'b1; end
      OP_XORI:  begin bundle.alu_op = ALU_XOR;  kind = IMM_ZEXT; write_rt = 1'b1; end
      OP_LUI: begin
        bundle.alu_op = ALU_OR;
        bundle.zero_a = 1'b1;
        kind          = IMM_LUI;
        write_rt      = 1'b1;
      end
      OP_LW:    begin bundle.alu_op = ALU_ADD;  kind = IMM_SEXT; write_rt = 1'b1; end
      OP_SW:    begin bundle.alu_op = ALU_ADD;  kind = IMM_SEXT; end
      // Branch offset is still extended for later use, but B comes from rt.
      OP_BEQ, OP_BNE: begin bundle.alu_op = ALU_SUB; kind = IMM_SEXT; end
      default: legal = 1'b0;
    endcase

    bundle.src_imm = (kind != IMM_NONE) && (op != OP_BEQ) && (op != OP_BNE);

    if (write_rd)      dest = instr[15:11];
    else if (write_rt) dest = instr[20:16];

    if (!legal) begin
      bundle.alu_op  = ALU_AND;
      bundle.src_imm = 1'b0;
      bundle.zero_a  = 1'b0;
      kind           = IMM_NONE;
      dest           = '0;
    end

    bundle.imm   = extend_imm(kind, instr[15:0]);
    bundle.wen   = (dest != 5'd0);
    bundle.waddr = dest;

`ifdef ALU_DECODE_TRAP_EN
    bundle.illegal = !legal;
`else
    bundle.illegal = 1'b0;
`endif
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ID->EX decode stage: decoder on the input side feeding a
// two-entry elastic buffer (main + skid) so in_ready is a pure register output.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu_decode_stage_if.slave  bus
);

  dec_bundle_t dec;
  dec_bundle_t main_q, main_d;
  dec_bundle_t skid_q, skid_d;
  buf_state_e  state_q, state_d;
  logic        in_fire;
  logic        out_fire;

  alu_decode_comb #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .instr  (bus.in_instr),
    .bundle (dec)
  );

  assign bus.in_ready  = (state_q != BUF_FULL);
  assign bus.out_valid = (state_q != BUF_EMPTY);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (in_fire) begin
          main_d  = dec;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (in_fire && !out_fire) begin
          skid_d  = dec;
          state_d = BUF_FULL;
        end else if (in_fire) begin
          main_d  = dec;
        end else if (out_fire) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.out_alu_op  = main_q.alu_op;
  assign bus.out_src_imm = main_q.src_imm;
  assign bus.out_zero_a  = main_q.zero_a;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_rs      = main_q.rs;
  assign bus.out_rt      = main_q.rt;
  assign bus.out_waddr   = main_q.waddr;
  assign bus.out_wen     = main_q.wen;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed decode vectors, handshake
// scenarios and randomized traffic against a queue-based reference model.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [2:0]  alu_op;
    logic        src_imm;
    logic        zero_a;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  waddr;
    logic        wen;
    logic        illegal;
    logic        imm_chk;
  } exp_t;

`ifdef ALU_DECODE_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_decode_stage_if #(.DATA_WIDTH(32)) bus ();

  alu_decode_stage #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: ALU meaning of each supported MIPS instruction.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] dst;
    bit ok;
    op = w[31:26];
    fn = w[5:0];
    ok = 1;
    dst = 5'd0;
    e = '0;
    e.rs = w[25:21];
    e.rt = w[20:16];
    e.imm_chk = 1'b1;
    case (op)
      6'h00: begin
        e.imm_chk = 1'b0;
        dst = w[15:11];
        case (fn)
          6'h21: e.alu_op = 3'b010;
          6'h23: e.alu_op = 3'b110;
          6'h24: e.alu_op = 3'b000;
          6'h25: e.alu_op = 3'b001;
          6'h26: e.alu_op = 3'b100;
          6'h27: e.alu_op = 3'b101;
          6'h2A: e.alu_op = 3'b111;
          6'h2B: e.alu_op = 3'b011;
          default: ok = 0;
        endcase
      end
      6'h09: begin e.alu_op = 3'b010; e.src_imm = 1; e.imm = {{16{w[15]}}, w[15:0]}; dst = w[20:16]; end
      6'h0A: begin e.alu_op = 3'b111; e.src_imm = 1; e.imm = {{16{w[15]}}, w[15:0]}; dst = w[20:16]; end
      6'h0B: begin e.alu_op = 3'b011; e.src_imm = 1; e.imm = {{16{w[15]}}, w[15:0]}; dst = w[20:16]; end
      6'h0C: begin e.alu_op = 3'b000; e.src_imm = 1; e.imm = {16'h0, w[15:0]}; dst = w[20:16]; end
      6'h0D: begin e.alu_op = 3'b001; e.src_imm = 1; e.imm = {16'h0, w[15:0]}; dst = w[20:16]; end
      6'h0E: begin e.alu_op = 3'b100; e.src_imm = 1; e.imm = {16'h0, w[15:0]}; dst = w[20:16]; end
      6'h0F: begin e.alu_op = 3'b001; e.src_imm = 1; e.zero_a = 1; e.imm = {w[15:0], 16'h0}; dst = w[20:16]; end
      6'h23: begin e.alu_op = 3'b010; e.src_imm = 1; e.imm = {{16{w[15]}}, w[15:0]}; dst = w[20:16]; end
      6'h2B: begin e.alu_op = 3'b010; e.src_imm = 1; e.imm = {{16{w[15]}}, w[15:0]}; end
      6'h04, 6'h05: begin e.alu_op = 3'b110; e.imm_chk = 1'b0; end
      default: ok = 0;
    endcase
    if (!ok) begin
      e.alu_op = 3'b000; e.src_imm = 0; e.zero_a = 0; e.imm = '0;
      e.imm_chk = 1'b1; dst = 5'd0; e.illegal = TRAP;
    end
    e.wen = (dst != 5'd0);
    e.waddr = dst;
    return e;
  endfunction

  function automatic exp_t mk(input logic [2:0] alu, input logic src, input logic za,
                              input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] wa, input logic wen, input logic ill,
                              input logic chk);
    exp_t e;
    e.alu_op = alu; e.src_imm = src; e.zero_a = za; e.imm = imm; e.rs = rs; e.rt = rt;
    e.waddr = wa; e.wen = wen; e.illegal = ill; e.imm_chk = chk;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.alu_op = bus.out_alu_op; o.src_imm = bus.out_src_imm; o.zero_a = bus.out_zero_a;
    o.imm = bus.out_imm; o.rs = bus.out_rs; o.rt = bus.out_rt; o.waddr = bus.out_waddr;
    o.wen = bus.out_wen; o.illegal = bus.out_illegal; o.imm_chk = 1'b0;
    return o;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops[11] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
    logic [5:0] fns[8]  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 7))
      0: ;
      1, 2: begin
        w[31:26] = 6'h00;
        w[5:0] = fns[$urandom_range(0, 7)];
        if ($urandom_range(0, 3) == 0) w[15:11] = 5'd0;
      end
      default: begin
        w[31:26] = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 3) == 0) w[20:16] = 5'd0;
      end
    endcase
    return w;
  endfunction

  // One handshake cycle: drives inputs, updates the scoreboard, returns what fired.
  task automatic drive_cycle(input logic iv, input logic [31:0] ins, input logic ordy,
                             output logic ifire, output logic ofire, output logic have,
                             output exp_t obs, output exp_t ex);
    bus.in_valid = iv;
    bus.in_instr = ins;
    bus.out_ready = ordy;
    ifire = iv & bus.in_ready;
    ofire = bus.out_valid & ordy;
    obs = observe();
    have = (q.size() != 0);
    ex = have ? q[0] : '0;
    if (ofire && have) void'(q.pop_front());
    if (ifire) q.push_back(model(ins));
    if (have && !ex.imm_chk) obs.imm = ex.imm;
    obs.imm_chk = ex.imm_chk;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t o;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
    o = observe();
    n_cmp++;
    if (o !== exp_t'('0)) begin
      n_bad++;
      $display("FAIL reset_bundle: got %h expected 0", o);
    end
  endtask

  task automatic test_directed();
    logic [31:0] w[6] = '{32'h2405FFFF, 32'h30238000, 32'h3C071234,
                          32'h0022002B, 32'h10220004, 32'hAC220008};
    exp_t e[6];
    exp_t o;
    e[0] = mk(3'b010, 1, 0, 32'hFFFFFFFF, 5'd0, 5'd5, 5'd5, 1, 0, 1);
    e[1] = mk(3'b000, 1, 0, 32'h00008000, 5'd1, 5'd3, 5'd3, 1, 0, 1);
    e[2] = mk(3'b001, 1, 1, 32'h12340000, 5'd0, 5'd7, 5'd7, 1, 0, 1);
    e[3] = mk(3'b011, 0, 0, 32'h0,        5'd1, 5'd2, 5'd0, 0, 0, 0);
    e[4] = mk(3'b110, 0, 0, 32'h0,        5'd1, 5'd2, 5'd0, 0, 0, 0);
    e[5] = mk(3'b010, 1, 0, 32'h00000008, 5'd1, 5'd2, 5'd0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = w[i];
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      o = observe();
      if (!e[i].imm_chk) o.imm = e[i].imm;
      o.imm_chk = e[i].imm_chk;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || o !== e[i]) begin
        n_bad++;
        $display("FAIL directed_%0d: valid=%b got %h expected %h", i, bus.out_valid, o, e[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_illegal();
    logic [31:0] w[2] = '{32'hFC000000, 32'h00221000};
    exp_t e[2];
    exp_t o;
    e[0] = mk(3'b000, 0, 0, 32'h0, 5'd0, 5'd0, 5'd0, 0, TRAP, 1);
    e[1] = mk(3'b000, 0, 0, 32'h0, 5'd1, 5'd2, 5'd0, 0, TRAP, 1);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = w[i];
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      o = observe();
      o.imm_chk = 1'b1;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || o !== e[i]) begin
        n_bad++;
        $display("FAIL illegal_%0d: valid=%b got %h expected %h", i, bus.out_valid, o, e[i]);
      end
      n_cmp++;
      if (bus.out_illegal !== TRAP) begin
        n_bad++;
        $display("FAIL illegal_flag_%0d: got %b expected %b", i, bus.out_illegal, TRAP);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[4];
    logic ifire, ofire, have;
    exp_t obs, ex;
    int unsigned idx = 0;
    int unsigned outs = 0;
    for (int i = 0; i < 4; i++) w[i] = rand_instr();
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, w[idx], 1'b0, ifire, ofire, have, obs, ex);
      if (ifire) idx++;
    end
    n_cmp++;
    if (idx != 2 || bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_stall: accepted=%0d in_ready=%b expected 2/0", idx, bus.in_ready);
    end
    for (int c = 0; c < 30 && (idx < 4 || q.size() != 0); c++) begin
      drive_cycle(idx < 4, (idx < 4) ? w[idx] : 32'h0, 1'b1, ifire, ofire, have, obs, ex);
      if (ifire) idx++;
      if (ofire) begin
        outs++;
        n_cmp++;
        if (!have || obs !== ex) begin
          n_bad++;
          $display("FAIL bp_order: got %h expected %h", obs, ex);
        end
      end
    end
    n_cmp++;
    if (outs != 4 || q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_count: delivered %0d pending %0d expected 4/0", outs, q.size());
    end
  endtask

  task automatic test_throughput();
    logic ifire, ofire, have;
    exp_t obs, ex;
    int unsigned idx = 0, outs = 0, drops = 0;
    int first = -1, last = -1;
    for (int c = 0; c < 40 && outs < 16; c++) begin
      if (idx < 16 && bus.in_ready !== 1'b1) drops++;
      drive_cycle(idx < 16, rand_instr(), 1'b1, ifire, ofire, have, obs, ex);
      if (ifire) idx++;
      if (ofire) begin
        outs++;
        if (first < 0) first = c;
        last = c;
        n_cmp++;
        if (!have || obs !== ex) begin
          n_bad++;
          $display("FAIL tp_data: got %h expected %h", obs, ex);
        end
      end
    end
    n_cmp++;
    if (drops != 0 || outs != 16 || (last - first + 1) != 16) begin
      n_bad++;
      $display("FAIL tp_rate: ready_drops=%0d outs=%0d span=%0d expected 0/16/16",
               drops, outs, last - first + 1);
    end
  endtask

  task automatic test_random();
    logic ifire, ofire, have, iv, ordy;
    exp_t obs, ex, held, now;
    logic stalled = 1'b0;
    for (int c = 0; c < 400; c++) begin
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      n_cmp++;
      if (bus.in_ready !== (q.size() < 2) || bus.out_valid !== (q.size() != 0)) begin
        n_bad++;
        $display("FAIL rnd_hs: in_ready=%b out_valid=%b occupancy=%0d",
                 bus.in_ready, bus.out_valid, q.size());
      end
      now = observe();
      if (stalled) begin
        n_cmp++;
        if (now !== held) begin
          n_bad++;
          $display("FAIL rnd_stable: got %h held %h", now, held);
        end
      end
      stalled = bus.out_valid && !ordy;
      held = now;
      drive_cycle(iv, rand_instr(), ordy, ifire, ofire, have, obs, ex);
      if (ofire) begin
        n_cmp++;
        if (!have || obs !== ex) begin
          n_bad++;
          $display("FAIL rnd_data: got %h expected %h", obs, ex);
        end
      end
    end
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      drive_cycle(1'b0, 32'h0, 1'b1, ifire, ofire, have, obs, ex);
      if (ofire) begin
        n_cmp++;
        if (!have || obs !== ex) begin
          n_bad++;
          $display("FAIL rnd_drain: got %h expected %h", obs, ex);
        end
      end
    end
    n_cmp++;
    if (q.size() != 0 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rnd_empty: pending=%0d out_valid=%b expected 0/0", q.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset_full();
    logic ifire, ofire, have;
    exp_t obs, ex;
    drive_cycle(1'b1, rand_instr(), 1'b0, ifire, ofire, have, obs, ex);
    drive_cycle(1'b1, rand_instr(), 1'b0, ifire, ofire, have, obs, ex);
    n_cmp++;
    if (bus.in_ready !== 1'b0 || q.size() != 2) begin
      n_bad++;
      $display("FAIL rf_fill: in_ready=%b accepted=%0d expected 0/2", bus.in_ready, q.size());
    end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rf_clear: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
    drive_cycle(1'b1, 32'h3C071234, 1'b1, ifire, ofire, have, obs, ex);
    drive_cycle(1'b0, 32'h0, 1'b1, ifire, ofire, have, obs, ex);
    n_cmp++;
    if (!ofire || !have || obs !== ex) begin
      n_bad++;
      $display("FAIL rf_next: fired=%b got %h expected %h", ofire, obs, ex);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_backpressure();
    test_throughput();
    test_random();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
